// File: rtl/mcp_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM:
// states, opcodes and datapath select values.
package mcp_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } mcp_state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] B_SEL_REG     = 2'b00;
    localparam logic [1:0] B_SEL_FOUR    = 2'b01;
    localparam logic [1:0] B_SEL_IMM     = 2'b10;
    localparam logic [1:0] B_SEL_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mcp_main_fsm_if.sv
// Control bundle between the main FSM (master) and the datapath (slave).
interface mcp_main_fsm_if;
    logic [5:0] op_i6;
    logic       zero_i;
    logic       pc_we_o;
    logic       branch_o;
    logic       pc_en_o;
    logic       instr_or_data_o;
    logic       instr_we_o;
    logic       enable_wmem_o;
    logic       enable_wrf_o;
    logic       reg_dst_o;
    logic       mem_to_reg_o;
    logic       a_alu_input_o;
    logic [1:0] b_alu_input_o2;
    logic [1:0] alu_op_o2;
    logic [1:0] pc_src_o2;
    logic       instr_done_o;
    logic       illegal_o;

    modport master (
        input  op_i6, zero_i,
        output pc_we_o, branch_o, pc_en_o, instr_or_data_o, instr_we_o,
               enable_wmem_o, enable_wrf_o, reg_dst_o, mem_to_reg_o,
               a_alu_input_o, b_alu_input_o2, alu_op_o2, pc_src_o2,
               instr_done_o, illegal_o
    );

    modport slave (
        output op_i6, zero_i,
        input  pc_we_o, branch_o, pc_en_o, instr_or_data_o, instr_we_o,
               enable_wmem_o, enable_wrf_o, reg_dst_o, mem_to_reg_o,
               a_alu_input_o, b_alu_input_o2, alu_op_o2, pc_src_o2,
               instr_done_o, illegal_o
    );
endinterface

// File: rtl/mcp_main_fsm.sv
// Multicycle MIPS main control FSM; datapath enables and selects are Moore
// outputs of the state register, with write strobes gated off during reset.
//
//   state   | meaning
//   FETCH   | read instruction at PC, PC <= PC + 4
//   DECODE  | read registers, precompute branch target
//   MEMADR  | compute load/store address
//   MEMRD   | read data memory at ALUOut
//   MEMWB   | write loaded word to rt
//   MEMWR   | write register B to memory at ALUOut
//   EXECUTE | R-type ALU operation
//   ALUWB   | write ALU result to rd
//   BRANCH  | compare, conditionally load branch target
//   ADDIEX  | register A + immediate
//   ADDIWB  | write addi result to rt
//   JUMP    | load jump target into PC
module mcp_main_fsm
    import mcp_pkg::*;
(
    input  logic          clk_i,
    input  logic          reset_i,
    mcp_main_fsm_if.master bus
);

    localparam logic [3:0] ST_FETCH   = FETCH;
    localparam logic [3:0] ST_DECODE  = DECODE;
    localparam logic [3:0] ST_MEMADR  = MEMADR;
    localparam logic [3:0] ST_MEMRD   = MEMRD;
    localparam logic [3:0] ST_MEMWB   = MEMWB;
    localparam logic [3:0] ST_MEMWR   = MEMWR;
    localparam logic [3:0] ST_EXECUTE = EXECUTE;
    localparam logic [3:0] ST_ALUWB   = ALUWB;
    localparam logic [3:0] ST_BRANCH  = BRANCH;
    localparam logic [3:0] ST_ADDIEX  = ADDIEX;
    localparam logic [3:0] ST_ADDIWB  = ADDIWB;
    localparam logic [3:0] ST_JUMP    = JUMP;

    logic [3:0] state_q;
    logic [3:0] state_d;

    logic       pc_we_raw;
    logic       branch_raw;
    logic       instr_we_raw;
    logic       wmem_raw;
    logic       wrf_raw;
    logic       done_raw;
    logic       illegal_raw;

    always_ff @(posedge clk_i) begin
        if (!reset_i) state_q <= ST_FETCH;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH:   state_d = ST_DECODE;
            ST_DECODE: begin
                case (bus.op_i6)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_RTYPE:     state_d = ST_EXECUTE;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_ADDI:      state_d = ST_ADDIEX;
                    OP_J:         state_d = ST_JUMP;
                    default:      state_d = ST_FETCH;
                endcase
            end
            ST_MEMADR:  state_d = (bus.op_i6 == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:   state_d = ST_MEMWB;
            ST_EXECUTE: state_d = ST_ALUWB;
            ST_ADDIEX:  state_d = ST_ADDIWB;
            default:    state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        pc_we_raw           = 1'b0;
        branch_raw          = 1'b0;
        instr_we_raw        = 1'b0;
        wmem_raw            = 1'b0;
        wrf_raw             = 1'b0;
        done_raw            = 1'b0;
        illegal_raw         = 1'b0;
        bus.instr_or_data_o = 1'b0;
        bus.reg_dst_o       = 1'b0;
        bus.mem_to_reg_o    = 1'b0;
        bus.a_alu_input_o   = 1'b0;
        bus.b_alu_input_o2  = B_SEL_REG;
        bus.alu_op_o2       = ALU_OP_ADD;
        bus.pc_src_o2       = PC_SRC_ALU;
        case (state_q)
            ST_FETCH: begin
                instr_we_raw       = 1'b1;
                pc_we_raw          = 1'b1;
                bus.b_alu_input_o2 = B_SEL_FOUR;
            end
            ST_DECODE: begin
                bus.b_alu_input_o2 = B_SEL_IMM_SH2;
                illegal_raw        = !op_supported(bus.op_i6);
            end
            ST_MEMADR, ST_ADDIEX: begin
                bus.a_alu_input_o  = 1'b1;
                bus.b_alu_input_o2 = B_SEL_IMM;
            end
            ST_MEMRD: bus.instr_or_data_o = 1'b1;
            ST_MEMWR: begin
                bus.instr_or_data_o = 1'b1;
                wmem_raw            = 1'b1;
                done_raw            = 1'b1;
            end
            ST_MEMWB: begin
                wrf_raw          = 1'b1;
                bus.mem_to_reg_o = 1'b1;
                done_raw         = 1'b1;
            end
            ST_EXECUTE: begin
                bus.a_alu_input_o = 1'b1;
                bus.alu_op_o2     = ALU_OP_FUNCT;
            end
            ST_ALUWB: begin
                wrf_raw       = 1'b1;
                bus.reg_dst_o = 1'b1;
                done_raw      = 1'b1;
            end
            ST_ADDIWB: begin
                wrf_raw  = 1'b1;
                done_raw = 1'b1;
            end
            ST_BRANCH: begin
                bus.a_alu_input_o = 1'b1;
                bus.alu_op_o2     = ALU_OP_SUB;
                bus.pc_src_o2     = PC_SRC_ALUOUT;
                branch_raw        = 1'b1;
                done_raw          = 1'b1;
            end
            ST_JUMP: begin
                bus.pc_src_o2 = PC_SRC_JUMP;
                pc_we_raw     = 1'b1;
                done_raw      = 1'b1;
            end
            default: ;
        endcase
    end

    // Gating with reset_i also masks the X state before the first reset edge.
    assign bus.pc_we_o       = reset_i & pc_we_raw;
    assign bus.branch_o      = reset_i & branch_raw;
    assign bus.pc_en_o       = reset_i & (pc_we_raw | (branch_raw & bus.zero_i));
    assign bus.instr_we_o    = reset_i & instr_we_raw;
    assign bus.enable_wmem_o = reset_i & wmem_raw;
    assign bus.enable_wrf_o  = reset_i & wrf_raw;
    assign bus.instr_done_o  = reset_i & done_raw;
    assign bus.illegal_o     = reset_i & illegal_raw;

endmodule

// File: doc/mcp_main_fsm.md
# mcp_main_fsm

Multicycle main control FSM for the MIPS core. It sequences each instruction through fetch, decode, execute, memory and writeback states and drives the datapath's write enables and mux selects as Moore outputs of its state register. It sits directly upstream of the datapath and feeds the controller side of the core. The ALU-function decoder consumes `alu_op_o2` and `funct`; that decoder is outside this block.

## Interface
- No parameters; opcode and state encodings come from the shared package.
- `clk_i`  in  1  core clock; all state changes on rising edge.
- `reset_i`  in  1  synchronous, active-low reset.
- `op_i6`  in  6  opcode field `instr[31:26]` from the instruction register.
- `zero_i`  in  1  ALU zero flag.
- `pc_we_o`  out  1  unconditional PC write.
- `branch_o`  out  1  conditional PC write (beq).
- `pc_en_o`  out  1  `pc_we_o | (branch_o & zero_i)`; combinational.
- `instr_or_data_o`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `instr_we_o`  out  1  instruction register write.
- `enable_wmem_o`  out  1  memory write strobe.
- `enable_wrf_o`  out  1  register file write.
- `reg_dst_o`  out  1  destination register select: 0 = rt, 1 = rd.
- `mem_to_reg_o`  out  1  register-file write data select: 0 = ALUOut, 1 = data register.
- `a_alu_input_o`  out  1  ALU A select: 0 = PC, 1 = register A.
- `b_alu_input_o2`  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `alu_op_o2`  out  2  ALU op class: 00 = add, 01 = subtract, 10 = use funct.
- `pc_src_o2`  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `instr_done_o`  out  1  one-cycle pulse in the last state of each instruction.
- `illegal_o`  out  1  one-cycle pulse when DECODE sees an unsupported opcode.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP. The state register is 4 bits.
- Transitions:
  - FETCH → DECODE.
  - DECODE branches on `op_i6`:
    - 100011 (lw) or 101011 (sw) → MEMADR.
    - 000000 (R-type) → EXECUTE.
    - 000100 (beq) → BRANCH.
    - 001000 (addi) → ADDIEX.
    - 000010 (j) → JUMP.
    - any other opcode → FETCH, with `illegal_o` = 1.
  - MEMADR → MEMRD if lw, MEMWR if sw. The opcode is re-read; the instruction register is stable.
  - MEMRD → MEMWB.
  - EXECUTE → ALUWB.
  - ADDIEX → ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP → FETCH.
- Outputs by state. Any output not listed is 0.
  - FETCH: `instr_we_o` = 1, `pc_we_o` = 1, `b_alu_input_o2` = 01.
  - DECODE: `b_alu_input_o2` = 11 (branch target precompute).
  - MEMADR, ADDIEX: `a_alu_input_o` = 1, `b_alu_input_o2` = 10.
  - MEMRD: `instr_or_data_o` = 1.
  - MEMWR: `instr_or_data_o` = 1, `enable_wmem_o` = 1.
  - MEMWB: `enable_wrf_o` = 1, `mem_to_reg_o` = 1.
  - EXECUTE: `a_alu_input_o` = 1, `alu_op_o2` = 10.
  - ALUWB: `enable_wrf_o` = 1, `reg_dst_o` = 1.
  - ADDIWB: `enable_wrf_o` = 1.
  - BRANCH: `a_alu_input_o` = 1, `alu_op_o2` = 01, `pc_src_o2` = 01, `branch_o` = 1.
  - JUMP: `pc_src_o2` = 10, `pc_we_o` = 1.
- `instr_done_o` is 1 in MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP.
- The illegal-opcode path does not assert `instr_done_o`.
- Unreachable state encodings → FETCH on the next edge. All outputs are 0 while in an unreachable encoding.

## Timing
- Cycles per instruction, counted from entering FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- All outputs except `pc_en_o` are Moore: they are valid from the clock edge that enters the state and hold for the whole cycle.
- `pc_en_o` follows `zero_i` combinationally, within the same cycle.
- Reset:
  - A rising edge with `reset_i` = 0 loads FETCH.
  - While `reset_i` = 0, these outputs are forced to 0 combinationally regardless of state: `pc_we_o`, `branch_o`, `pc_en_o`, `instr_we_o`, `enable_wmem_o`, `enable_wrf_o`, `instr_done_o`, `illegal_o`.
  - Select outputs take the FETCH values after the first reset edge.
- Reset mid-instruction: the instruction is abandoned. No further write of any kind occurs for it.
- The first cycle after reset is released is a full FETCH cycle.
- `op_i6` is sampled only in DECODE and MEMADR. Its value in any other state is don't-care.

## Structure
- Shared package `mcp_pkg` holds:
  - the state enum `mcp_state_e`;
  - opcode constants `OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_ADDI`, `OP_J`;
  - `alu_op` encodings;
  - `b_alu_input` select encodings;
  - `pc_src` select encodings.
- Structure is a single module: a next-state `always_comb`, an output `always_comb`, and an `always_ff` state register. No sub-module is warranted.

## Test plan
- Reset: hold `reset_i` = 0 for 3 cycles with `op_i6` = 100011 → every write enable is 0 throughout. After release, the first cycle has `pc_we_o` = 1, `instr_we_o` = 1 and `b_alu_input_o2` = 01.
- lw (`op_i6` = 100011) → state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB. `instr_or_data_o` = 1 in cycle 4; `enable_wrf_o` = 1 with `mem_to_reg_o` = 1 in cycle 5; `instr_done_o` pulses once.
- sw, R-type and addi (101011, 000000, 001000) → 4 cycles each:
  - sw: `enable_wmem_o` = 1 only in cycle 4;
  - R-type: `alu_op_o2` = 10 in EXECUTE, `reg_dst_o` = 1 in ALUWB;
  - addi: `reg_dst_o` = 0 in ADDIWB.
- beq (000100) with `zero_i` = 1, then a second beq with `zero_i` = 0 → `pc_en_o` = 1 in BRANCH for the first and 0 for the second. `pc_src_o2` = 01 and `alu_op_o2` = 01 in both.
- j (000010) → 3 cycles; `pc_we_o` = 1 and `pc_src_o2` = 10 in cycle 3. Illegal opcode 111111 → `illegal_o` pulses in DECODE, then FETCH, with no write enables asserted.
- Reset asserted in MEMADR of an sw → FETCH on that edge, and `enable_wmem_o` is never asserted.
